// File: rtl/simon_pkg.sv
// Shared Simon definitions: button count, colour index width, player-input
// FSM states and the colour-to-lamp one-hot decoder.
package simon_pkg;

    localparam int unsigned NUM_BUTTONS = 4;
    localparam int unsigned COLOR_W     = 2;

    // Player-input FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } player_state_e;

    // Colour index to one-hot lamp vector
    function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [COLOR_W-1:0] idx);
        onehot = NUM_BUTTONS'(1) << idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button conditioner: 2-flop synchronizer followed by a counter-based
// debouncer. The stable level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with it.
//   clk, reset : clock, asynchronous active-high reset
//   btn_raw    : raw asynchronous button level
//   btn_db     : debounced (stable) level, registered
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens on the next mismatch
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer chain and debounce counter
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_db = stable_q;

endmodule

// File: rtl/simon_player_input.sv
// Player-side front end of the Simon game. Conditions four raw buttons,
// accepts exactly one press per physical push (gated by simonTurn/gameOver),
// and drives the four colour lamps.
//   clk, reset    : game clock, asynchronous active-high reset
//   btn[3:0]      : raw buttons, bit i = colour i
//   simonTurn     : controller is playing its sequence (gates input)
//   simonNum      : colour Simon is showing
//   simonPressed  : Simon's colour is lit
//   gameOver      : game ended (gates input, all lamps on)
//   playerNum     : index of last accepted press, held between presses
//   playerPressed : one-cycle pulse, playerNum valid in the same cycle
//   lights[3:0]   : one-hot colour lamps
module simon_player_input
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn,
    input  logic                   simonTurn,
    input  logic [COLOR_W-1:0]     simonNum,
    input  logic                   simonPressed,
    input  logic                   gameOver,
    output logic [COLOR_W-1:0]     playerNum,
    output logic                   playerPressed,
    output logic [NUM_BUTTONS-1:0] lights
);

    logic [NUM_BUTTONS-1:0] db;

    player_state_e          state_q, state_d;
    logic [COLOR_W-1:0]     player_num_q, player_num_d;
    logic                   player_pressed_q, player_pressed_d;
    logic [NUM_BUTTONS-1:0] lights_q, lights_d;

    logic                   db_single_c;
    logic [COLOR_W-1:0]     db_idx_c;

    // Per-button synchronizer + debouncer
    for (genvar g = 0; g < int'(NUM_BUTTONS); g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn[g]),
            .btn_db (db[g])
        );
    end

    // Exactly-one-bit detect and index of the set bit
    always_comb begin
        db_single_c = (db != '0) && ((db & (db - NUM_BUTTONS'(1))) == '0);
        db_idx_c    = '0;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (db[i]) begin
                db_idx_c = COLOR_W'(i);
            end
        end
    end

    // Next state, press pulse and lamp mux
    always_comb begin
        state_d          = state_q;
        player_num_d     = player_num_q;
        player_pressed_d = 1'b0;
        lights_d         = '0;

        unique case (state_q)
            IDLE: begin
                if (db != '0) begin
                    if (db_single_c && !simonTurn && !gameOver) begin
                        player_num_d     = db_idx_c;
                        player_pressed_d = 1'b1;
                        state_d          = HELD;
                    end else begin
                        // Chord or gated press: swallow it until full release
                        state_d = LOCKOUT;
                    end
                end
            end
            HELD, LOCKOUT: begin
                if (db == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lamps reflect the state being entered so they line up with the pulse
        if (gameOver) begin
            lights_d = '1;
        end else if (simonTurn) begin
            lights_d = simonPressed ? onehot(simonNum) : '0;
        end else if (state_d == HELD) begin
            lights_d = onehot(player_num_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            player_num_q     <= '0;
            player_pressed_q <= 1'b0;
            lights_q         <= '0;
        end else begin
            state_q          <= state_d;
            player_num_q     <= player_num_d;
            player_pressed_q <= player_pressed_d;
            lights_q         <= lights_d;
        end
    end

    assign playerNum     = player_num_q;
    assign playerPressed = player_pressed_q;
    assign lights        = lights_q;

endmodule

// File: tb/tb_simon_player_input.sv
// Bench for simon_player_input: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_simon_player_input;

    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [3:0] lights;

    int tests = 0;
    int fails = 0;

    simon_player_input #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .simonTurn    (simonTurn),
        .simonNum     (simonNum),
        .simonPressed (simonPressed),
        .gameOver     (gameOver),
        .playerNum    (playerNum),
        .playerPressed(playerPressed),
        .lights       (lights)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Debounced level of a button flips once the last DB samples seen by the
    // debouncer (raw samples delayed two edges by the synchronizer) all
    // disagree with it. hist[k] is the raw value sampled k edges ago.
    logic [3:0] hist [0:DB+1];
    logic [3:0] m_db;
    int         m_mode;        // 0 = waiting, 1 = accepted press held, 2 = ignored until release
    logic [1:0] m_num;
    logic       m_pressed;
    logic [3:0] m_lights;
    int         nbits;
    int         idx;
    logic       all_diff;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= int'(DB) + 1; k++) hist[k] = 4'b0;
            m_db = 4'b0; m_mode = 0; m_num = 2'd0; m_pressed = 1'b0; m_lights = 4'b0;
        end else begin
            nbits = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (m_db[i]) begin nbits++; idx = i; end
            m_pressed = 1'b0;
            if (m_mode == 0) begin
                if (nbits == 1 && !simonTurn && !gameOver) begin
                    m_num = 2'(idx); m_pressed = 1'b1; m_mode = 1;
                end else if (nbits > 0) begin
                    m_mode = 2;
                end
            end else if (nbits == 0) begin
                m_mode = 0;
            end
            if (gameOver)       m_lights = 4'b1111;
            else if (simonTurn) m_lights = simonPressed ? (4'b0001 << simonNum) : 4'b0000;
            else if (m_mode == 1) m_lights = 4'b0001 << m_num;
            else                m_lights = 4'b0000;
            for (int k = int'(DB) + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= int'(DB) + 1; k++) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) m_db[i] = ~m_db[i];
            end
        end
        #1;
        check("cyc_playerPressed", 32'(playerPressed), 32'(m_pressed));
        check("cyc_playerNum",     32'(playerNum),     32'(m_num));
        check("cyc_lights",        32'(lights),        32'(m_lights));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watch n edges; report pulse count and the edge index of the first pulse
    task automatic watch(input int n, output int pulses, output int first_edge);
        pulses = 0; first_edge = -1;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #2;
            if (playerPressed) begin
                pulses++;
                if (first_edge < 0) first_edge = e;
            end
        end
        @(negedge clk);
    endtask

    int pulses, first_edge, seg_hold, r;

    initial begin
        reset = 1'b1; btn = 4'b0; simonTurn = 1'b0; simonNum = 2'd0;
        simonPressed = 1'b0; gameOver = 1'b0;
        #1;
        check("reset_playerNum",     32'(playerNum),     32'd0);
        check("reset_playerPressed", 32'(playerPressed), 32'd0);
        check("reset_lights",        32'(lights),        32'd0);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);

        // Single press of colour 2
        btn = 4'b0100;
        watch(10, pulses, first_edge);
        check("press2_pulses",  32'(pulses),     32'd1);
        check("press2_latency", 32'(first_edge), 32'(DB + 3));
        check("press2_num",     32'(playerNum),  32'd2);
        check("press2_lights",  32'(lights),     32'b0100);
        btn = 4'b0000;
        wait_cycles(DB + 5);
        check("release_lights", 32'(lights), 32'd0);

        // Short glitch on button 1
        btn = 4'b0010; wait_cycles(2); btn = 4'b0000;
        watch(10, pulses, first_edge);
        check("glitch_pulses", 32'(pulses),    32'd0);
        check("glitch_num",    32'(playerNum), 32'd2);
        check("glitch_lights", 32'(lights),    32'd0);

        // Two-button chord, then a clean single press
        btn = 4'b0011;
        watch(10, pulses, first_edge);
        check("chord_pulses", 32'(pulses), 32'd0);
        check("chord_lights", 32'(lights), 32'd0);
        btn = 4'b0000; wait_cycles(DB + 5);
        btn = 4'b0001;
        watch(10, pulses, first_edge);
        check("after_chord_pulses", 32'(pulses),    32'd1);
        check("after_chord_num",    32'(playerNum), 32'd0);
        btn = 4'b0000; wait_cycles(DB + 5);

        // Press during Simon's turn, then turn ends while still held
        simonTurn = 1'b1; simonNum = 2'd3; simonPressed = 1'b1;
        btn = 4'b0001;
        watch(10, pulses, first_edge);
        check("simon_turn_pulses", 32'(pulses), 32'd0);
        check("simon_turn_lights", 32'(lights), 32'b1000);
        simonTurn = 1'b0; simonPressed = 1'b0;
        watch(10, pulses, first_edge);
        check("turn_end_held_pulses", 32'(pulses), 32'd0);
        btn = 4'b0000; wait_cycles(DB + 5);
        btn = 4'b0001;
        watch(10, pulses, first_edge);
        check("repress_pulses", 32'(pulses), 32'd1);
        btn = 4'b0000; wait_cycles(DB + 5);

        // Game over
        gameOver = 1'b1; wait_cycles(2);
        check("gameover_lights", 32'(lights), 32'b1111);
        btn = 4'b1000;
        watch(10, pulses, first_edge);
        check("gameover_pulses", 32'(pulses), 32'd0);
        btn = 4'b0000; gameOver = 1'b0; wait_cycles(DB + 5);

        // Reset mid-press, button held across reset release
        btn = 4'b1000; wait_cycles(DB + 5);
        check("held3_lights", 32'(lights),    32'b1000);
        check("held3_num",    32'(playerNum), 32'd3);
        reset = 1'b1; #1;
        check("midreset_num",     32'(playerNum),     32'd0);
        check("midreset_pressed", 32'(playerPressed), 32'd0);
        check("midreset_lights",  32'(lights),        32'd0);
        wait_cycles(2);
        reset = 1'b0;
        watch(10, pulses, first_edge);
        check("post_reset_latency", 32'(first_edge), 32'(DB + 3));
        check("post_reset_num",     32'(playerNum),  32'd3);
        btn = 4'b0000; wait_cycles(DB + 5);

        // Randomized segments checked by the model every cycle
        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      btn = 4'b0000;
            else if (r < 7) btn = 4'b0001 << $urandom_range(0, 3);
            else            btn = 4'($urandom_range(0, 15));
            simonTurn    = ($urandom_range(0, 4) == 0);
            gameOver     = ($urandom_range(0, 19) == 0);
            simonNum     = 2'($urandom_range(0, 3));
            simonPressed = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 49) == 0);
            seg_hold     = (r == 9) ? int'($urandom_range(1, DB)) : int'($urandom_range(1, 12));
            wait_cycles(seg_hold);
            reset = 1'b0;
        end
        btn = 4'b0000; simonTurn = 1'b0; gameOver = 1'b0;
        wait_cycles(DB + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
